neighbor_sched: RTL and testbench
=================================

NEIGHBOR_SCHED -- requirements
Module: neighbor_sched

Interface
REQ-001 Parameter MAXW, default 512, sets the maximum line length in pixels and the line-buffer depth.
REQ-002 Parameter CW, default 10, sets the width of the column and row counters and of the width/height inputs.
REQ-003 clk  in  1  single clock; all logic rises on posedge clk.
REQ-004 rst_n  in  1  reset; synchronous, active-high (asserted = 1); the name is kept for codebase consistency.
REQ-005 start  in  1  one-cycle pulse that begins a frame using img_w and img_h.
REQ-006 abort  in  1  synchronous frame cancel.
REQ-007 img_w, img_h  in  CW each  frame width and height in pixels.
REQ-008 s_valid / s_ready / s_pix  in / out / in  1 / 1 / 16  raster-order pixel input stream.
REQ-009 Rx, Ra, Rb, Rc, Rd  out  16 each  current pixel and its causal neighbours.
REQ-010 D1, D2, D3  out  17 each  two's-complement gradients for the predictor.
REQ-011 data_en / m_ready  out / in  1 / 1  output-valid and downstream accept.
REQ-012 busy, done, err  out  1 each  frame active, end-of-frame pulse, bad-config pulse.

Function
REQ-013 State machine has states IDLE, RUN and DRAIN.
REQ-014 IDLE to RUN occurs on start when 2<=img_w<=MAXW and img_h>=1; img_w and img_h are latched, and col and row are cleared.
REQ-015 A start with an illegal config keeps the block in IDLE and pulses err for one cycle.
REQ-016 start is ignored outside IDLE.
REQ-017 s_ready = (state==RUN) && (!data_en || m_ready).
REQ-018 A pixel is accepted on a cycle where s_valid && s_ready.
REQ-019 Latency: an accepted pixel appears on Rx, with its neighbours and gradients, registered, with data_en=1 on the next cycle.
REQ-020 While data_en && !m_ready, all outputs hold stable.
REQ-021 data_en clears when m_ready=1 and no new pixel is accepted that cycle.
REQ-022 Neighbour selection (col c, row r, line buffer LB holding the previous row), first row (r==0): Rb=Rc=Rd=0; Ra=0 at c==0, otherwise Ra = previous Rx.
REQ-023 Neighbour selection for r>0: Rb=LB[c]; Rd=LB[c+1], except Rd=Rb at c==img_w-1.
REQ-024 For r>0, c>0: Ra = previous Rx, and Rc = the Rb of the previous pixel.
REQ-025 For r>0, c==0: Ra=Rb, and Rc = the Rb captured at c==0 of the previous row (0 when r==1).
REQ-026 LB[c] is written with s_pix on accept; the read of LB[c] and LB[c+1] returns pre-write contents.
REQ-027 Gradients are computed on sign-extended 17-bit values: D1=Rd-Rb, D2=Rb-Rc, D3=Rc-Ra, modulo 2^17.
REQ-028 col increments on accept; at img_w-1 it wraps to 0 and row increments.
REQ-029 Acceptance of pixel (img_h-1, img_w-1) moves the state to DRAIN, and s_ready drops.
REQ-030 DRAIN to IDLE occurs when the last output is accepted (data_en && m_ready); done pulses for one cycle on that same edge.
REQ-031 busy = (state != IDLE).
REQ-032 abort in any state forces IDLE, clears data_en and the counters, and produces no done pulse.
REQ-033 abort takes priority over a simultaneous accept or start.
REQ-034 The line buffer is not cleared between frames; row-0 muxing makes stale contents invisible.

Reset
REQ-035 While rst_n=1 on a clock edge, the block enters IDLE.
REQ-036 On reset, col, row and the latched dimensions go to 0.
REQ-037 On reset, data_en, s_ready, busy, done and err go to 0.
REQ-038 On reset, Rx/Ra/Rb/Rc/Rd and D1-D3 go to 0.
REQ-039 Reset mid-frame discards the frame with no done pulse, and takes priority over every other input.
REQ-040 Line-buffer contents are undefined after reset and are never observable.

Verification
REQ-041 Scenario: img_w=4, img_h=2, pixels 10..17, m_ready=1 -> pixel (1,2)=16 outputs Ra=15, Rb=12, Rc=11, Rd=13, D1=1, D2=1, D3=-4; done pulses 1 cycle after the last data_en.
REQ-042 Scenario: same frame -> row 0 outputs Rb=Rc=Rd=0; pixel (1,0) gives Ra=Rb=10, Rc=0; pixel (1,3) gives Rd=Rb=13.
REQ-043 Scenario: hold m_ready=0 for 3 cycles mid-frame -> outputs stable, s_ready=0, no pixel lost, and the sequence matches the unstalled run.
REQ-044 Scenario: start with img_w=1, or img_w=MAXW+1, or img_h=0 -> err pulses once, busy stays 0.
REQ-045 Scenario: abort after 5 pixels, then a new start -> no done for the aborted frame; the first row of the new frame shows Rb=Rc=Rd=0 despite stale line-buffer data.
REQ-046 Scenario: rst_n=1 for one cycle mid-frame -> all outputs 0 on the next cycle, state IDLE.

Source files
------------

// File: rtl/neighbor_sched.sv
// Causal-neighbour scheduler: streams raster pixels with Ra/Rb/Rc/Rd and
// gradients D1..D3, using one line buffer holding the previous row.
module neighbor_sched #(
    parameter int MAXW = 512,
    parameter int CW   = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] img_w,
    input  logic [CW-1:0] img_h,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [15:0]   s_pix,
    output logic [15:0]   Rx,
    output logic [15:0]   Ra,
    output logic [15:0]   Rb,
    output logic [15:0]   Rc,
    output logic [15:0]   Rd,
    output logic [16:0]   D1,
    output logic [16:0]   D2,
    output logic [16:0]   D3,
    output logic          data_en,
    input  logic          m_ready,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CW:0] MAXW_C = (CW+1)'(MAXW);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] col;
    logic [CW-1:0] row;
    logic [CW-1:0] w_q;
    logic [CW-1:0] h_q;
    logic [CW-1:0] col_p1;
    logic [15:0]   lb [MAXW];
    logic [15:0]   rb_c0;
    logic [15:0]   ra_n;
    logic [15:0]   rb_n;
    logic [15:0]   rc_n;
    logic [15:0]   rd_n;
    logic          cfg_ok;
    logic          accept;
    logic          first_row;
    logic          first_col;
    logic          last_col;
    logic          last_row;
    logic          done_nxt;
    logic          err_nxt;

    assign cfg_ok = (img_w >= CW'(2)) && ({1'b0, img_w} <= MAXW_C) && (img_h != '0);
    assign s_ready = (state == RUN) && (!data_en || m_ready);
    assign accept = s_valid && s_ready;
    assign busy = (state != IDLE);
    assign col_p1 = col + 1'b1;
    assign first_row = (row == '0);
    assign first_col = (col == '0);
    assign last_col = (col == w_q - 1'b1);
    assign last_row = (row == h_q - 1'b1);

    // Row 0 forces the upper neighbours to zero, hiding stale line-buffer data.
    always_comb begin
        rb_n = '0;
        rd_n = '0;
        rc_n = '0;
        if (!first_row) begin
            rb_n = lb[col[AW-1:0]];
            rd_n = last_col ? rb_n : lb[col_p1[AW-1:0]];
            rc_n = first_col ? rb_c0 : Rb;
        end
        ra_n = first_col ? rb_n : Rx;
    end

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (abort) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) state_nxt = RUN;
                        else err_nxt = 1'b1;
                    end
                end
                RUN: begin
                    if (accept && last_col && last_row) state_nxt = DRAIN;
                end
                DRAIN: begin
                    if (data_en && m_ready) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n && !abort && accept) lb[col[AW-1:0]] <= s_pix;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            col     <= '0;
            row     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            rb_c0   <= '0;
            data_en <= 1'b0;
            Rx      <= '0;
            Ra      <= '0;
            Rb      <= '0;
            Rc      <= '0;
            Rd      <= '0;
            D1      <= '0;
            D2      <= '0;
            D3      <= '0;
        end else if (abort) begin
            col     <= '0;
            row     <= '0;
            data_en <= 1'b0;
        end else begin
            if (state == IDLE && start && cfg_ok) begin
                w_q <= img_w;
                h_q <= img_h;
                col <= '0;
                row <= '0;
            end
            if (accept) begin
                Rx      <= s_pix;
                Ra      <= ra_n;
                Rb      <= rb_n;
                Rc      <= rc_n;
                Rd      <= rd_n;
                D1      <= {rd_n[15], rd_n} - {rb_n[15], rb_n};
                D2      <= {rb_n[15], rb_n} - {rc_n[15], rc_n};
                D3      <= {rc_n[15], rc_n} - {ra_n[15], ra_n};
                data_en <= 1'b1;
                if (first_col) rb_c0 <= rb_n;
                if (last_col) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col_p1;
                end
            end else if (m_ready) begin
                data_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_neighbor_sched.sv
// Directed bench for neighbor_sched: 4x2 frames, stall, bad configs,
// abort and mid-frame reset.
module tb_neighbor_sched;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [9:0]  img_w = '0;
    logic [9:0]  img_h = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [15:0] s_pix = '0;
    logic [15:0] Rx, Ra, Rb, Rc, Rd;
    logic [16:0] D1, D2, D3;
    logic        data_en;
    logic        m_ready = 1'b1;
    logic        busy, done, err;

    int n_checks = 0;
    int n_errors = 0;

    // Hand-derived neighbours for the 4x2 frame with pixels 10..17
    int e_rx[8] = '{10, 11, 12, 13, 14, 15, 16, 17};
    int e_ra[8] = '{0, 10, 11, 12, 10, 14, 15, 16};
    int e_rb[8] = '{0, 0, 0, 0, 10, 11, 12, 13};
    int e_rc[8] = '{0, 0, 0, 0, 0, 10, 11, 12};
    int e_rd[8] = '{0, 0, 0, 0, 11, 12, 13, 13};

    neighbor_sched #(.MAXW(512), .CW(10)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .img_w(img_w), .img_h(img_h),
        .s_valid(s_valid), .s_ready(s_ready), .s_pix(s_pix),
        .Rx(Rx), .Ra(Ra), .Rb(Rb), .Rc(Rc), .Rd(Rd),
        .D1(D1), .D2(D2), .D3(D3),
        .data_en(data_en), .m_ready(m_ready),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_pix(input int i);
        logic [16:0] d1, d2, d3;
        d1 = 17'(e_rd[i] - e_rb[i]);
        d2 = 17'(e_rb[i] - e_rc[i]);
        d3 = 17'(e_rc[i] - e_ra[i]);
        chk($sformatf("en%0d", i), data_en, 1);
        chk($sformatf("rx%0d", i), Rx, e_rx[i]);
        chk($sformatf("ra%0d", i), Ra, e_ra[i]);
        chk($sformatf("rb%0d", i), Rb, e_rb[i]);
        chk($sformatf("rc%0d", i), Rc, e_rc[i]);
        chk($sformatf("rd%0d", i), Rd, e_rd[i]);
        chk($sformatf("d1_%0d", i), D1, d1);
        chk($sformatf("d2_%0d", i), D2, d2);
        chk($sformatf("d3_%0d", i), D3, d3);
        if (i == 6) chk("d3_px6_neg4", D3, 32'h0001FFFC);
    endtask

    task automatic begin_frame();
        @(posedge clk); #1;
        img_w = 10'd4;
        img_h = 10'd2;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input int stall_at);
        begin_frame();
        chk("busy_start", busy, 1);
        for (int i = 0; i < 8; i++) begin
            s_valid = 1'b1;
            s_pix = 16'(10 + i);
            if (i == stall_at) begin
                m_ready = 1'b0;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_rdy", s_ready, 0);
                    chk("stall_rx", Rx, e_rx[i-1]);
                    chk("stall_ra", Ra, e_ra[i-1]);
                    chk("stall_en", data_en, 1);
                    @(posedge clk); #1;
                end
                m_ready = 1'b1;
            end
            @(negedge clk);
            chk("s_ready", s_ready, 1);
            @(posedge clk); #1;
            check_pix(i);
        end
        s_valid = 1'b0;
        chk("drain_rdy", s_ready, 0);
        chk("drain_busy", busy, 1);
        chk("drain_done", done, 0);
        @(posedge clk); #1;
        chk("done_pulse", done, 1);
        chk("done_en", data_en, 0);
        chk("done_busy", busy, 0);
        @(posedge clk); #1;
        chk("done_clear", done, 0);
    endtask

    task automatic bad_start(input logic [9:0] w, input logic [9:0] h);
        @(posedge clk); #1;
        img_w = w;
        img_h = h;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk($sformatf("err_w%0d_h%0d", w, h), err, 1);
        chk("err_busy", busy, 0);
        @(posedge clk); #1;
        chk("err_once", err, 0);
        chk("err_idle", busy, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_en", data_en, 0);
        chk("rst_rdy", s_ready, 0);
        chk("rst_rx", Rx, 0);
        chk("rst_d3", D3, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b0;

        run_frame(-1);
        run_frame(5);

        bad_start(10'd1, 10'd2);
        bad_start(10'd513, 10'd2);
        bad_start(10'd4, 10'd0);

        begin_frame();
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1;
            s_pix = 16'(200 + i);
            @(posedge clk); #1;
        end
        chk("abort_pre_rx", Rx, 204);
        s_pix = 16'd99;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        s_valid = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_en", data_en, 0);
        chk("abort_rdy", s_ready, 0);
        chk("abort_rx", Rx, 204);
        chk("abort_done0", done, 0);
        @(posedge clk); #1;
        chk("abort_done1", done, 0);
        run_frame(-1);

        begin_frame();
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_pix = 16'(300 + i);
            @(posedge clk); #1;
        end
        chk("mid_rx", Rx, 302);
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        s_valid = 1'b0;
        chk("mrst_rx", Rx, 0);
        chk("mrst_ra", Ra, 0);
        chk("mrst_d3", D3, 0);
        chk("mrst_en", data_en, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_rdy", s_ready, 0);
        chk("mrst_done", done, 0);
        @(posedge clk); #1;
        chk("mrst_done1", done, 0);
        chk("mrst_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
